// File: rtl/lcd_timing_gen.sv
// RGB-LCD timing generator. After reset it waits SETTLE_CYC cycles for the ID reader,
// latches lcd_id[2:0] once, decodes the panel timing set, then free-runs sync/DE timing,
// a pixel request strobe one cycle ahead of DE, and gates pixel data onto the panel bus.
// Optional feature: define LCD_SYNC_MODE_EN to drive active-low hsync/vsync; otherwise
// the panel runs in pure DE mode with lcd_hs/lcd_vs held high.
module lcd_timing_gen #(
  parameter int unsigned SETTLE_CYC = 16
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [15:0] lcd_id,
  input  logic [15:0] pixel_data,
  output logic [15:0] panel_id,
  output logic [10:0] h_disp,
  output logic [10:0] v_disp,
  output logic        data_req,
  output logic [10:0] pixel_xpos,
  output logic [10:0] pixel_ypos,
  output logic        lcd_hs,
  output logic        lcd_vs,
  output logic        lcd_de,
  output logic        lcd_bl,
  output logic        lcd_rst,
  output logic [15:0] lcd_rgb
);

  localparam int unsigned SettleW = (SETTLE_CYC > 2) ? $clog2(SETTLE_CYC) : 1;
  localparam logic [SettleW-1:0] SettleLast = SettleW'(SETTLE_CYC - 1);

  typedef enum logic [1:0] {StWait, StLock, StRun} state_e;

  state_e               state_q;
  logic [SettleW-1:0]   settle_q;
  logic [10:0]          h_cnt_q, v_cnt_q;
  logic [15:0]          panel_id_q;
  logic [10:0]          h_sync_q, h_start_q, h_disp_q, h_total_q;
  logic [10:0]          v_sync_q, v_start_q, v_disp_q, v_total_q;
  logic                 req_q, de_q, hs_q, vs_q, bl_q, rst_q;
  logic [10:0]          xpos_q, ypos_q;

  // Only the low three ID bits select a panel.
  logic unused_id;
  assign unused_id = ^lcd_id[15:3];

  logic [15:0] dec_pid;
  logic [10:0] dec_h_sync, dec_h_start, dec_h_disp, dec_h_total;
  logic [10:0] dec_v_sync, dec_v_start, dec_v_disp, dec_v_total;

  // Decode the panel ID into sync width, active start (sync+back), active size and total.
  always_comb begin
    dec_pid     = 16'h4342;
    dec_h_sync  = 11'd41;  dec_h_start = 11'd43;  dec_h_disp = 11'd480;  dec_h_total = 11'd525;
    dec_v_sync  = 11'd10;  dec_v_start = 11'd12;  dec_v_disp = 11'd272;  dec_v_total = 11'd286;
    case (lcd_id[2:0])
      3'b001, 3'b100: begin
        dec_pid    = (lcd_id[2:0] == 3'b001) ? 16'h7084 : 16'h4384;
        dec_h_sync = 11'd128; dec_h_start = 11'd216; dec_h_disp = 11'd800;  dec_h_total = 11'd1056;
        dec_v_sync = 11'd2;   dec_v_start = 11'd35;  dec_v_disp = 11'd480;  dec_v_total = 11'd525;
      end
      3'b010: begin
        dec_pid    = 16'h7016;
        dec_h_sync = 11'd20;  dec_h_start = 11'd160; dec_h_disp = 11'd1024; dec_h_total = 11'd1344;
        dec_v_sync = 11'd3;   dec_v_start = 11'd23;  dec_v_disp = 11'd600;  dec_v_total = 11'd635;
      end
      3'b101: begin
        dec_pid    = 16'h1018;
        dec_h_sync = 11'd10;  dec_h_start = 11'd90;  dec_h_disp = 11'd1280; dec_h_total = 11'd1440;
        dec_v_sync = 11'd3;   dec_v_start = 11'd13;  dec_v_disp = 11'd800;  dec_v_total = 11'd823;
      end
      default: ;
    endcase
  end

  // During LOCK the latched set is not yet valid, so the first RUN outputs use the decode.
  logic        use_dec;
  logic [10:0] cur_h_sync, cur_h_start, cur_h_disp, cur_h_total;
  logic [10:0] cur_v_sync, cur_v_start, cur_v_disp, cur_v_total;
  assign use_dec     = (state_q == StLock);
  assign cur_h_sync  = use_dec ? dec_h_sync  : h_sync_q;
  assign cur_h_start = use_dec ? dec_h_start : h_start_q;
  assign cur_h_disp  = use_dec ? dec_h_disp  : h_disp_q;
  assign cur_h_total = use_dec ? dec_h_total : h_total_q;
  assign cur_v_sync  = use_dec ? dec_v_sync  : v_sync_q;
  assign cur_v_start = use_dec ? dec_v_start : v_start_q;
  assign cur_v_disp  = use_dec ? dec_v_disp  : v_disp_q;
  assign cur_v_total = use_dec ? dec_v_total : v_total_q;

  logic [10:0] h_nxt, v_nxt, h_req, xpos_nxt, ypos_nxt;
  logic        v_act, de_nxt, req_nxt, hs_nxt, vs_nxt;

  // Next counter values and the outputs they imply, so every output is registered.
  always_comb begin
    h_nxt = '0;
    v_nxt = '0;
    if (state_q == StRun) begin
      if (h_cnt_q == cur_h_total - 11'd1) begin
        v_nxt = (v_cnt_q == cur_v_total - 11'd1) ? 11'd0 : v_cnt_q + 11'd1;
      end else begin
        h_nxt = h_cnt_q + 11'd1;
        v_nxt = v_cnt_q;
      end
    end
    h_req    = h_nxt + 11'd1;
    v_act    = (v_nxt >= cur_v_start) && (v_nxt < cur_v_start + cur_v_disp);
    de_nxt   = v_act && (h_nxt >= cur_h_start) && (h_nxt < cur_h_start + cur_h_disp);
    req_nxt  = v_act && (h_req >= cur_h_start) && (h_req < cur_h_start + cur_h_disp);
    xpos_nxt = req_nxt ? h_req - cur_h_start : 11'd0;
    ypos_nxt = req_nxt ? v_nxt - cur_v_start : 11'd0;
`ifdef LCD_SYNC_MODE_EN
    hs_nxt   = (h_nxt >= cur_h_sync);
    vs_nxt   = (v_nxt >= cur_v_sync);
`else
    hs_nxt   = 1'b1;
    vs_nxt   = 1'b1;
`endif
  end

  // Control FSM, timing latch and registered panel outputs.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StWait;
      settle_q   <= '0;
      h_cnt_q    <= '0;
      v_cnt_q    <= '0;
      panel_id_q <= '0;
      h_sync_q   <= '0; h_start_q <= '0; h_disp_q <= '0; h_total_q <= '0;
      v_sync_q   <= '0; v_start_q <= '0; v_disp_q <= '0; v_total_q <= '0;
      req_q      <= 1'b0;
      de_q       <= 1'b0;
      hs_q       <= 1'b1;
      vs_q       <= 1'b1;
      bl_q       <= 1'b0;
      rst_q      <= 1'b0;
      xpos_q     <= '0;
      ypos_q     <= '0;
    end else begin
      case (state_q)
        StWait: begin
          settle_q <= settle_q + 1'b1;
          if (settle_q == SettleLast) state_q <= StLock;
        end
        StLock: begin
          panel_id_q <= dec_pid;
          h_sync_q   <= dec_h_sync; h_start_q <= dec_h_start;
          h_disp_q   <= dec_h_disp; h_total_q <= dec_h_total;
          v_sync_q   <= dec_v_sync; v_start_q <= dec_v_start;
          v_disp_q   <= dec_v_disp; v_total_q <= dec_v_total;
          bl_q       <= 1'b1;
          rst_q      <= 1'b1;
          state_q    <= StRun;
        end
        StRun:   ;
        default: state_q <= StWait;
      endcase
      if (state_q != StWait) begin
        h_cnt_q <= h_nxt;
        v_cnt_q <= v_nxt;
        req_q   <= req_nxt;
        de_q    <= de_nxt;
        hs_q    <= hs_nxt;
        vs_q    <= vs_nxt;
        xpos_q  <= xpos_nxt;
        ypos_q  <= ypos_nxt;
      end
    end
  end

  assign panel_id   = panel_id_q;
  assign h_disp     = h_disp_q;
  assign v_disp     = v_disp_q;
  assign data_req   = req_q;
  assign pixel_xpos = xpos_q;
  assign pixel_ypos = ypos_q;
  assign lcd_hs     = hs_q;
  assign lcd_vs     = vs_q;
  assign lcd_de     = de_q;
  assign lcd_bl     = bl_q;
  assign lcd_rst    = rst_q;
  assign lcd_rgb    = de_q ? pixel_data : 16'd0;

endmodule

// File: tb/tb_lcd_timing_gen.sv
// Bench for lcd_timing_gen: predicts every output from the panel timing table using
// cycle-count arithmetic (h = t mod H_TOTAL, v = line mod V_TOTAL) with random pixel data.
module tb_lcd_timing_gen;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [15:0] lcd_id = 16'd0;
  logic [15:0] pixel_data = 16'd0;
  logic [15:0] panel_id;
  logic [10:0] h_disp, v_disp, pixel_xpos, pixel_ypos;
  logic        data_req, lcd_hs, lcd_vs, lcd_de, lcd_bl, lcd_rst;
  logic [15:0] lcd_rgb;

  lcd_timing_gen #(.SETTLE_CYC(16)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .lcd_id     (lcd_id),
    .pixel_data (pixel_data),
    .panel_id   (panel_id),
    .h_disp     (h_disp),
    .v_disp     (v_disp),
    .data_req   (data_req),
    .pixel_xpos (pixel_xpos),
    .pixel_ypos (pixel_ypos),
    .lcd_hs     (lcd_hs),
    .lcd_vs     (lcd_vs),
    .lcd_de     (lcd_de),
    .lcd_bl     (lcd_bl),
    .lcd_rst    (lcd_rst),
    .lcd_rgb    (lcd_rgb)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference panel description (SYNC, SYNC+BACK, DISP, TOTAL per axis).
  int unsigned m_hsync, m_hstart, m_hdisp, m_htot;
  int unsigned m_vsync, m_vstart, m_vdisp, m_vtot;
  logic [15:0] m_pid;
  int unsigned t;            // cycles since the first RUN cycle
  bit          use_fixed = 1'b0;
  int          de_cnt, hs_lo_cnt, first_req_t;

  localparam logic [81:0] ResetVec =
    {16'h0, 11'd0, 11'd0, 1'b0, 11'd0, 11'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 16'h0};

  task automatic set_model(input logic [2:0] id);
    int unsigned hs, hb, hd, hf, vs, vb, vd, vf;
    case (id)
      3'b001, 3'b100: begin
        hs = 128; hb = 88;  hd = 800;  hf = 40;  vs = 2; vb = 33; vd = 480; vf = 10;
        m_pid = (id == 3'b001) ? 16'h7084 : 16'h4384;
      end
      3'b010: begin
        hs = 20;  hb = 140; hd = 1024; hf = 160; vs = 3; vb = 20; vd = 600; vf = 12;
        m_pid = 16'h7016;
      end
      3'b101: begin
        hs = 10;  hb = 80;  hd = 1280; hf = 70;  vs = 3; vb = 10; vd = 800; vf = 10;
        m_pid = 16'h1018;
      end
      default: begin
        hs = 41;  hb = 2;   hd = 480;  hf = 2;   vs = 10; vb = 2; vd = 272; vf = 2;
        m_pid = 16'h4342;
      end
    endcase
    m_hsync = hs; m_hstart = hs + hb; m_hdisp = hd; m_htot = hs + hb + hd + hf;
    m_vsync = vs; m_vstart = vs + vb; m_vdisp = vd; m_vtot = vs + vb + vd + vf;
  endtask

  function automatic logic [81:0] expect_vec(input int unsigned tt, input logic [15:0] pix);
    int unsigned h, v;
    logic va, de, req, hs, vs;
    logic [10:0] x, y;
    h   = tt % m_htot;
    v   = (tt / m_htot) % m_vtot;
    va  = (v >= m_vstart) && (v < m_vstart + m_vdisp);
    de  = va && (h >= m_hstart) && (h < m_hstart + m_hdisp);
    req = va && (h + 1 >= m_hstart) && (h + 1 < m_hstart + m_hdisp);
    x   = req ? 11'(h + 1 - m_hstart) : 11'd0;
    y   = req ? 11'(v - m_vstart) : 11'd0;
`ifdef LCD_SYNC_MODE_EN
    hs  = (h >= m_hsync);
    vs  = (v >= m_vsync);
`else
    hs  = 1'b1;
    vs  = 1'b1;
`endif
    return {m_pid, 11'(m_hdisp), 11'(m_vdisp), req, x, y, de, hs, vs, 1'b1, 1'b1,
            de ? pix : 16'h0};
  endfunction

  function automatic logic [81:0] actual_vec();
    return {panel_id, h_disp, v_disp, data_req, pixel_xpos, pixel_ypos, lcd_de, lcd_hs,
            lcd_vs, lcd_bl, lcd_rst, lcd_rgb};
  endfunction

  // Compare every output against the model for n cycles, advancing t.
  task automatic run_check(input int n);
    logic [81:0] exp_v, act_v;
    for (int i = 0; i < n; i++) begin
      pixel_data = use_fixed ? 16'hF800 : 16'($urandom());
      #1;
      exp_v = expect_vec(t, pixel_data);
      act_v = actual_vec();
      checks++;
      if (act_v !== exp_v) begin
        errors++;
        $display("FAIL run_outputs t=%0d got=%h exp=%h", t, act_v, exp_v);
      end
      if (lcd_de) de_cnt++;
      if (!lcd_hs) hs_lo_cnt++;
      if (data_req && first_req_t < 0) first_req_t = int'(t);
      @(posedge clk);
      #1;
      t++;
    end
  endtask

  // Reset, settle, latch: checks LOCK-cycle outputs and the first RUN cycle header values.
  task automatic start_panel(input logic [2:0] id);
    logic [15:0] r;
    r = 16'($urandom());
    lcd_id = {r[15:3], id};
    set_model(id);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    repeat (16) @(posedge clk);
    #1;
    checks++;
    if (actual_vec() !== ResetVec) begin
      errors++;
      $display("FAIL lock_cycle_outputs got=%h exp=%h", actual_vec(), ResetVec);
    end
    @(posedge clk);
    #1;
    checks++;
    if ({panel_id, h_disp, v_disp, lcd_bl, lcd_rst} !==
        {m_pid, 11'(m_hdisp), 11'(m_vdisp), 1'b1, 1'b1}) begin
      errors++;
      $display("FAIL first_run_header got=%h/%0d/%0d/%b%b exp=%h/%0d/%0d/11",
               panel_id, h_disp, v_disp, lcd_bl, lcd_rst, m_pid, m_hdisp, m_vdisp);
    end
    t = 0;
    de_cnt = 0; hs_lo_cnt = 0; first_req_t = -1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    lcd_id = 16'h0001;
    repeat (2) @(posedge clk);
    #1;
    checks++;
    if (actual_vec() !== ResetVec) begin
      errors++;
      $display("FAIL reset_state got=%h exp=%h", actual_vec(), ResetVec);
    end
  endtask

  // Unlisted IDs fall back to 4342; constant red pixel is gated by DE.
  task automatic test_default_panel();
    logic [2:0] ids [3];
    ids[0] = 3'b011; ids[1] = 3'b110; ids[2] = 3'b111;
    start_panel(ids[$urandom_range(2, 0)]);
    use_fixed = 1'b1;
    run_check(14 * 525);
    use_fixed = 1'b0;
    checks++;
    if (de_cnt != 2 * 480) begin
      errors++;
      $display("FAIL default_de_count got=%0d exp=%0d", de_cnt, 2 * 480);
    end
  endtask

  // 7084: first request position, per-line DE/HS counts, ID change ignored, mid-line reset.
  task automatic test_7084_and_reset();
    logic [15:0] r;
    int exp_hs;
    start_panel(3'b001);
    run_check(100);
    r = 16'($urandom());
    lcd_id = {r[15:3], 3'b010};
    run_check(35 * 1056 - 100);
    checks++;
    if (first_req_t != -1) begin
      errors++;
      $display("FAIL early_req got_t=%0d exp=none", first_req_t);
    end
    de_cnt = 0; hs_lo_cnt = 0;
    run_check(1056);
    checks++;
    if (first_req_t != 35 * 1056 + 215) begin
      errors++;
      $display("FAIL first_req_t got=%0d exp=%0d", first_req_t, 35 * 1056 + 215);
    end
    checks++;
    if (de_cnt != 800) begin
      errors++;
      $display("FAIL de_per_line got=%0d exp=800", de_cnt);
    end
`ifdef LCD_SYNC_MODE_EN
    exp_hs = 128;
`else
    exp_hs = 0;
`endif
    checks++;
    if (hs_lo_cnt != exp_hs) begin
      errors++;
      $display("FAIL hs_low_per_line got=%0d exp=%0d", hs_lo_cnt, exp_hs);
    end
    run_check(300);
    rst_n = 1'b0;
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    checks++;
    if (actual_vec() !== ResetVec) begin
      errors++;
      $display("FAIL mid_line_reset got=%h exp=%h", actual_vec(), ResetVec);
    end
    start_panel(3'b010);
    run_check(2000);
  endtask

  task automatic test_other_panels();
    start_panel(3'b101);
    run_check(2000);
    start_panel(3'b100);
    run_check(2000);
  endtask

  initial begin
    test_reset();
    test_default_panel();
    test_7084_and_reset();
    test_other_panels();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
